// File: rtl/risc_pkg.sv
// Shared types and helpers for the four-requester round-robin bus arbiter.
package risc_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned SEL_W   = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } pick_t;

  function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [SEL_W-1:0] idx);
    logic [NUM_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

  // Search starts one past the last owner and wraps, so the last owner is tried last.
  function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] req,
                                    input logic [SEL_W-1:0]   last);
    pick_t            p;
    logic [SEL_W-1:0] idx;
    p = '0;
    for (int k = 1; k <= int'(NUM_REQ); k++) begin
      idx = last + SEL_W'(k);
      if (!p.found && req[idx]) begin
        p.found = 1'b1;
        p.idx   = idx;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/risc_mux4.sv
// 4:1 data selector placing the current owner's data on the shared bus.
module risc_mux4
  import risc_pkg::*;
(
  input  logic [SEL_W-1:0]  sel_i,
  input  logic [DATA_W-1:0] d0_i,
  input  logic [DATA_W-1:0] d1_i,
  input  logic [DATA_W-1:0] d2_i,
  input  logic [DATA_W-1:0] d3_i,
  output logic [DATA_W-1:0] y_o
);

  // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
  always_comb begin
    y_o = d0_i;
    case (sel_i)
      2'd1:    y_o = d1_i;
      2'd2:    y_o = d2_i;
      2'd3:    y_o = d3_i;
      default: y_o = d0_i;
    endcase
  end

endmodule

// File: rtl/risc_bus_arbiter.sv
// Round-robin arbiter for four requesters with a bounded burst length when others are waiting.
module risc_bus_arbiter
  import risc_pkg::*;
#(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_REQ-1:0]  req,
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  input  logic [DATA_W-1:0]   c,
  input  logic [DATA_W-1:0]   d,
  output logic [NUM_REQ-1:0]  gnt,
  output logic [SEL_W-1:0]    sel,
  output logic [DATA_W-1:0]   bus_out,
  output logic                bus_valid
);

  localparam logic [3:0] MAX_B = 4'(MAX_BURST);

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [SEL_W-1:0]   last_q, last_d;
  logic [3:0]         cnt_q, cnt_d;

  pick_t              pick;
  logic               owner_req;
  logic [NUM_REQ-1:0] others;
  logic [3:0]         cnt_inc;
  logic               burst_done;

  assign pick      = rr_pick(req, last_q);
  assign owner_req = req[sel_q];
  assign others    = req & ~idx_to_onehot(sel_q);

  // The burst limit is judged on the count including this cycle, so an owner keeps the bus exactly MAX_BURST cycles.
  assign cnt_inc    = (owner_req && (cnt_q != MAX_B)) ? cnt_q + 4'd1 : cnt_q;
  assign burst_done = (cnt_inc == MAX_B) && (others != '0);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick.found) begin
          state_d = ST_GRANT;
          sel_d   = pick.idx;
          last_d  = pick.idx;
          gnt_d   = idx_to_onehot(pick.idx);
          cnt_d   = '0;
        end
      end
      ST_GRANT: begin
        if (!owner_req || burst_done) begin
          cnt_d = '0;
          if (pick.found) begin
            sel_d  = pick.idx;
            last_d = pick.idx;
            gnt_d  = idx_to_onehot(pick.idx);
          end else begin
            state_d = ST_IDLE;
            gnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // NOTE: non-blocking assignments here so every register samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      last_q  <= 2'd3;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  risc_mux4 u_mux (
    .sel_i (sel_q),
    .d0_i  (a),
    .d1_i  (b),
    .d2_i  (c),
    .d3_i  (d),
    .y_o   (bus_out)
  );

  assign gnt       = gnt_q;
  assign sel       = sel_q;
  assign bus_valid = (gnt_q != '0) && req[sel_q];

endmodule

// File: tb/tb_risc_bus_arbiter.sv
// Directed scenarios for the round-robin bus arbiter with hand-computed expectations.
module tb_risc_bus_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [15:0] a, b, c, d;
  logic [3:0]  gnt;
  logic [1:0]  sel;
  logic [15:0] bus_out;
  logic        bus_valid;

  logic [15:0] data_tbl [4];
  int checks;
  int failures;

  risc_bus_arbiter #(.MAX_BURST(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .gnt       (gnt),
    .sel       (sel),
    .bus_out   (bus_out),
    .bus_valid (bus_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = 4'b0000;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req   = 4'b0000;
    #2;
    checks++;
    if (gnt !== 4'b0000) begin failures++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
    checks++;
    if (sel !== 2'b00) begin failures++; $display("FAIL reset_sel: got %b want 00", sel); end
    checks++;
    if (bus_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", bus_valid); end
    checks++;
    if (bus_out !== 16'h1234) begin failures++; $display("FAIL reset_bus: got %h want 1234", bus_out); end
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_single_grant();
    req = 4'b0001;
    step();
    checks++;
    if (gnt !== 4'b0001) begin failures++; $display("FAIL single_gnt: got %b want 0001", gnt); end
    checks++;
    if (sel !== 2'b00) begin failures++; $display("FAIL single_sel: got %b want 00", sel); end
    checks++;
    if (bus_out !== 16'h1234) begin failures++; $display("FAIL single_bus: got %h want 1234", bus_out); end
    checks++;
    if (bus_valid !== 1'b1) begin failures++; $display("FAIL single_valid: got %b want 1", bus_valid); end
    req = 4'b0000;
    step();
    checks++;
    if (gnt !== 4'b0000) begin failures++; $display("FAIL single_release: got %b want 0000", gnt); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_gnt;
    int         own;
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 20; k++) begin
      step();
      own     = (k / 4) % 4;
      exp_gnt = 4'b0001 << own;
      checks++;
      if (gnt !== exp_gnt) begin
        failures++; $display("FAIL rr_gnt cycle %0d: got %b want %b", k, gnt, exp_gnt);
      end
      checks++;
      if (bus_out !== data_tbl[own]) begin
        failures++; $display("FAIL rr_bus cycle %0d: got %h want %h", k, bus_out, data_tbl[own]);
      end
    end
    req = 4'b0000;
    step();
    checks++;
    if (gnt !== 4'b0000) begin failures++; $display("FAIL rr_idle: got %b want 0000", gnt); end
  endtask

  task automatic test_saturate();
    req = 4'b0100;
    for (int k = 0; k < 10; k++) begin
      step();
      checks++;
      if (gnt !== 4'b0100) begin
        failures++; $display("FAIL sat_gnt cycle %0d: got %b want 0100", k, gnt);
      end
    end
    // Counter held at the limit, so a new requester takes over on the very next edge.
    req = 4'b0101;
    step();
    checks++;
    if (gnt !== 4'b0001) begin failures++; $display("FAIL sat_handoff: got %b want 0001", gnt); end
    req = 4'b0000;
    step();
  endtask

  task automatic test_handover();
    req = 4'b0010;
    step();
    checks++;
    if (gnt !== 4'b0010) begin failures++; $display("FAIL ho_owner1: got %b want 0010", gnt); end
    step();
    req = 4'b1000;
    #1;
    checks++;
    if (bus_valid !== 1'b0) begin failures++; $display("FAIL ho_valid_drop: got %b want 0", bus_valid); end
    step();
    checks++;
    if (gnt !== 4'b1000) begin failures++; $display("FAIL ho_gnt: got %b want 1000", gnt); end
    checks++;
    if (sel !== 2'b11) begin failures++; $display("FAIL ho_sel: got %b want 11", sel); end
    checks++;
    if (bus_out !== 16'hDDDD) begin failures++; $display("FAIL ho_bus: got %h want dddd", bus_out); end
    req = 4'b0000;
    step();
    checks++;
    if (gnt !== 4'b0000) begin failures++; $display("FAIL ho_idle_gnt: got %b want 0000", gnt); end
    checks++;
    if (sel !== 2'b11) begin failures++; $display("FAIL ho_idle_sel: got %b want 11", sel); end
    checks++;
    if (bus_valid !== 1'b0) begin failures++; $display("FAIL ho_idle_valid: got %b want 0", bus_valid); end
  endtask

  task automatic test_wrap();
    req = 4'b0100;
    step();
    checks++;
    if (gnt !== 4'b0100) begin failures++; $display("FAIL wrap_owner2: got %b want 0100", gnt); end
    req = 4'b0001;
    step();
    checks++;
    if (gnt !== 4'b0001) begin failures++; $display("FAIL wrap_gnt: got %b want 0001", gnt); end
    checks++;
    if (sel !== 2'b00) begin failures++; $display("FAIL wrap_sel: got %b want 00", sel); end
    req = 4'b0000;
    step();
  endtask

  task automatic test_reset_mid_burst();
    req = 4'b0010;
    step();
    checks++;
    if (gnt !== 4'b0010) begin failures++; $display("FAIL rst_mid_pre: got %b want 0010", gnt); end
    step();
    req   = 4'b1111;
    reset = 1'b1;
    #1;
    checks++;
    if (gnt !== 4'b0000) begin failures++; $display("FAIL rst_mid_gnt: got %b want 0000", gnt); end
    checks++;
    if (sel !== 2'b00) begin failures++; $display("FAIL rst_mid_sel: got %b want 00", sel); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    step();
    checks++;
    if (gnt !== 4'b0001) begin failures++; $display("FAIL rst_mid_first: got %b want 0001", gnt); end
    req = 4'b0000;
    step();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    data_tbl[0] = 16'h1234;
    data_tbl[1] = 16'hBBBB;
    data_tbl[2] = 16'hCCCC;
    data_tbl[3] = 16'hDDDD;
    a = data_tbl[0];
    b = data_tbl[1];
    c = data_tbl[2];
    d = data_tbl[3];
    reset = 1'b1;
    req   = 4'b0000;

    test_reset();
    test_single_grant();
    test_round_robin();
    test_saturate();
    test_handover();
    test_wrap();
    test_reset_mid_burst();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/risc_bus_arbiter.md
RISC_BUS_ARBITER -- requirements
Module: risc_bus_arbiter

Interface
REQ-001 SHALL have parameter MAX_BURST, default 4: maximum consecutive granted cycles while another requester is pending (range 1..15).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port req  input  4  request per requester; bit i = requester i.
REQ-005 SHALL have port a  input  16  data of requester 0.
REQ-006 SHALL have port b  input  16  data of requester 1.
REQ-007 SHALL have port c  input  16  data of requester 2.
REQ-008 SHALL have port d  input  16  data of requester 3.
REQ-009 SHALL have port gnt  output  4  registered one-hot grant; all-zero when idle.
REQ-010 SHALL have port sel  output  2  registered owner index driving the data selector.
REQ-011 SHALL have port bus_out  output  16  selected data: a/b/c/d for sel 0/1/2/3.
REQ-012 SHALL have port bus_valid  output  1  high when gnt is non-zero and req[sel] is high.

Function
REQ-013 SHALL implement a two-state FSM: IDLE (gnt=0) and GRANT (gnt one-hot = 1<<sel).
REQ-014 In IDLE with any req bit high, SHALL enter GRANT on the next edge; req at cycle N gives gnt at cycle N+1.
REQ-015 SHALL choose the winner round-robin: search order starts at last_owner+1 mod 4 and wraps.
REQ-016 In GRANT, SHALL increment a 4-bit burst counter each cycle with req[sel] high; the counter saturates at MAX_BURST.
REQ-017 SHALL release the grant when req[sel] is low, or when the counter equals MAX_BURST and any other req bit is high.
REQ-018 On release with another requester pending, SHALL go GRANT->GRANT to the next round-robin winner on the same edge, with no idle cycle, and clear the counter.
REQ-019 On release with no requester pending, SHALL go to IDLE with gnt=0; sel keeps the last owner.
REQ-020 When the counter reaches MAX_BURST with no other requester pending, SHALL keep the grant and hold the counter at MAX_BURST.
REQ-021 If the owner drops req in the same cycle another raises it, SHALL grant the new requester on the next edge.
REQ-022 bus_out SHALL be combinational from sel and a..d; bus_valid SHALL be combinational from gnt, req and sel.
REQ-023 last_owner SHALL update to the winner at each grant.

Reset
REQ-024 While reset is high, SHALL force: FSM=IDLE, gnt=0000, sel=00, counter=0, last_owner=3 (requester 0 wins first).
REQ-025 Reset asserted mid-burst SHALL clear gnt immediately, without waiting for clk.
REQ-026 After reset deasserts, SHALL arbitrate normally starting on the first rising clk edge.

Structure
REQ-027 SHALL place the state encoding (IDLE=0, GRANT=1), the requester count (4) and the data width (16) in shared package risc_pkg.
REQ-028 SHALL instantiate one sub-module, risc_mux4, a 16-bit 4:1 data selector driven by sel.
REQ-029 SHALL contain no latches; every combinational output SHALL be assigned on all paths.

Verification
REQ-030 Reset then req=0001, a=16'h1234 -> next cycle gnt=0001, sel=00, bus_out=16'h1234, bus_valid=1.
REQ-031 req=1111 held constant, MAX_BURST=4 -> grants rotate 0,1,2,3,0, each for exactly 4 cycles, with no gap cycles.
REQ-032 req=0100 only, held 10 cycles -> gnt=0100 for all 10 cycles, counter holds at 4, grant never released.
REQ-033 Owner 1 drops req and req=1000 rises in the same cycle -> next edge gnt=1000, sel=11; once all requests drop -> gnt=0000, sel stays 11.
REQ-034 reset pulsed mid-burst with gnt=0010 -> gnt=0000 and sel=00 before the next clk edge; with req=1111 after release, the first grant is 0001.
REQ-035 Owner 2 drops req and req=0001 rises in the same cycle (last_owner=2) -> next edge gnt=0001, showing round-robin wrap from 3 to 0.
